// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type and arithmetic helpers for conv_window_mac
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    // Accumulator width: full product plus tree growth plus one bit for the bias add.
    function automatic int acc_width(input int dw, input int ww, input int taps);
        return dw + ww + $clog2(taps) + 1;
    endfunction

    function automatic int round_const(input int shift);
        return 1 << (shift - 1);
    endfunction

endpackage

// File: rtl/conv_dot_tree.sv
// rtl/conv_dot_tree.sv - registered products, then registered adder tree plus bias, with valid tag
module conv_dot_tree
    import conv_pkg::*;
#(
    parameter int TAPS = 72,
    parameter int DW   = 9,
    parameter int WW   = 8,
    parameter int BW   = 24,
    parameter int ACCW = acc_width(DW, WW, TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [TAPS*DW-1:0]   window,
    input  logic [TAPS*WW-1:0]   weights,
    input  logic [BW-1:0]        bias,
    output logic                 acc_valid,
    output logic [ACCW-1:0]      acc
);

    localparam int PW = DW + WW;

    logic signed [PW-1:0]   prod_d [TAPS];
    logic signed [PW-1:0]   prod_q [TAPS];
    logic signed [BW-1:0]   bias_q;
    logic signed [ACCW-1:0] sum_d;
    logic                   prod_valid;

    // Tap 0 sits in the most significant slice of both flattened vectors.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod_d[i] = PW'($signed(window[(TAPS-1-i)*DW +: DW]))
                      * PW'($signed(weights[(TAPS-1-i)*WW +: WW]));
        end
    end

    always_comb begin
        sum_d = ACCW'(bias_q);
        for (int i = 0; i < TAPS; i++) begin
            sum_d = sum_d + ACCW'(prod_q[i]);
        end
    end

    // Data registers run every cycle; only the valid tags are cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TAPS; i++) begin
            prod_q[i] <= prod_d[i];
        end
        bias_q <= bias;
        acc    <= sum_d;
        if (!rst_n || clr) begin
            prod_valid <= 1'b0;
            acc_valid  <= 1'b0;
        end else begin
            prod_valid <= in_valid;
            acc_valid  <= prod_valid;
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - window MAC stage with requantisation; optional ReLU via CONV_MAC_RELU_EN
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int CHANNEL = 8,
    parameter int K_SIZE  = 3,
    parameter int OUT_CH  = 16,
    parameter int DW      = 9,
    parameter int WW      = 8,
    parameter int BW      = 24,
    parameter int OW      = 9,
    parameter int SHIFT   = 7
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  win_valid,
    output logic                                  win_ready,
    input  logic [DW*K_SIZE*K_SIZE*CHANNEL-1:0]   window,
    output logic [$clog2(OUT_CH)-1:0]             w_addr,
    input  logic [WW*K_SIZE*K_SIZE*CHANNEL-1:0]   w_data,
    input  logic [BW-1:0]                         b_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OW*OUT_CH-1:0]                  out_data
);

    localparam int TAPS = K_SIZE * K_SIZE * CHANNEL;
    localparam int AW   = $clog2(OUT_CH);
    localparam int ACCW = acc_width(DW, WW, TAPS);
    localparam int RW   = ACCW + 1;
    localparam logic signed [RW-1:0] RND  = RW'(round_const(SHIFT));
    localparam logic signed [RW-1:0] OMAX = RW'((1 << (OW - 1)) - 1);
    localparam logic signed [RW-1:0] OMIN = RW'(-(1 << (OW - 1)));
    localparam logic [AW-1:0]        LAST = AW'(OUT_CH - 1);

    state_t                 state;
    logic [TAPS*DW-1:0]     win_q;
    logic                   issue_q;
    logic [AW-1:0]          wr_cnt;
    logic                   acc_valid;
    logic [ACCW-1:0]        acc;
    logic signed [RW-1:0]   rnd_sum;
    logic signed [RW-1:0]   shifted;
    logic signed [OW-1:0]   res;

    assign win_ready = (state == IDLE);

    conv_dot_tree #(
        .TAPS (TAPS),
        .DW   (DW),
        .WW   (WW),
        .BW   (BW),
        .ACCW (ACCW)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .in_valid  (issue_q),
        .window    (win_q),
        .weights   (w_data),
        .bias      (b_data),
        .acc_valid (acc_valid),
        .acc       (acc)
    );

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        rnd_sum = RW'($signed(acc)) + RND;
        shifted = rnd_sum >>> SHIFT;
`ifdef CONV_MAC_RELU_EN
        if (shifted < 0) shifted = '0;
`endif
        if (shifted > OMAX)      res = OMAX[OW-1:0];
        else if (shifted < OMIN) res = OMIN[OW-1:0];
        else                     res = shifted[OW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            w_addr    <= '0;
            wr_cnt    <= '0;
            issue_q   <= 1'b0;
            if (!rst_n) out_data <= '0;
        end else begin
            // ROM data for the address driven this cycle arrives next cycle.
            issue_q <= (state == RUN);
            if (acc_valid) begin
                out_data[(OUT_CH-1-wr_cnt)*OW +: OW] <= res;
                wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        win_q <= window;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (w_addr == LAST) begin
                        w_addr <= '0;
                        state  <= DRAIN;
                    end else begin
                        w_addr <= w_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (acc_valid && wr_cnt == LAST) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - scoreboard bench for conv_window_mac with a registered weight ROM model
module tb_conv_window_mac;

    localparam int TAPS = 72;
    localparam int OC   = 16;
    localparam int DW   = 9;
    localparam int WW   = 8;
    localparam int BW   = 24;
    localparam int OW   = 9;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 win_valid;
    logic                 win_ready;
    logic [TAPS*DW-1:0]   window;
    logic [3:0]           w_addr;
    logic [TAPS*WW-1:0]   w_data;
    logic [BW-1:0]        b_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW*OC-1:0]     out_data;

    int                   vecs;
    int                   errs;
    int                   mode;
    logic [3:0]           rom_addr_q;
    logic [OW*OC-1:0]     exp_q [$];

    conv_window_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .window    (window),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Weight ROM: mode 1 weights 1 / bias oc*128, mode 2 weights 127, mode 3 weights -1.
    always @(posedge clk) rom_addr_q <= w_addr;

    always_comb begin
        logic [WW-1:0] wv;
        wv = (mode == 2) ? 8'd127 : (mode == 3) ? 8'hFF : 8'd1;
        w_data = '0;
        for (int i = 0; i < TAPS; i++) w_data[i*WW +: WW] = wv;
        b_data = (mode == 1) ? BW'(int'(rom_addr_q) * 128) : '0;
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [TAPS*DW-1:0] fill_win(input int val);
        logic [TAPS*DW-1:0] w;
        for (int i = 0; i < TAPS; i++) w[i*DW +: DW] = DW'(val);
        return w;
    endfunction

    function automatic logic [OW*OC-1:0] expect_vec(input int m);
        logic [OW*OC-1:0] v;
        int val;
        for (int oc = 0; oc < OC; oc++) begin
            if (m == 1) val = oc + 1;
            else if (m == 2) val = 255;
            else begin
`ifdef CONV_MAC_RELU_EN
                val = 0;
`else
                val = -1;
`endif
            end
            v[(OC-1-oc)*OW +: OW] = OW'(val);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                check("out_vector", out_data, exp_q.pop_front());
            end
        end
    end

    // Returns one cycle after the accepting edge (cycle 1 relative to fire).
    task automatic fire(input logic [TAPS*DW-1:0] w);
        window    = w;
        win_valid = 1'b1;
        @(posedge clk);
        #1;
        win_valid = 1'b0;
    endtask

    task automatic run_window(input int m, input int wval);
        bit got;
        mode = m;
        exp_q.push_back(expect_vec(m));
        fire(fill_win(wval));
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) got = 1;
        end
        check("result_timeout", got, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        vecs = 0;
        errs = 0;
        mode = 1;
        rst_n = 1'b0;
        flush = 1'b0;
        win_valid = 1'b0;
        window = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("reset_out_valid", out_valid, 0);
        check("reset_win_ready", win_ready, 1);
        check("reset_w_addr", w_addr, 0);
        check("reset_out_data", out_data, 0);

        // Latency and address sequence, then back-pressure in HOLD.
        mode = 1;
        exp_q.push_back(expect_vec(1));
        fire(fill_win(1));
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (k <= 16) check("w_addr_seq", w_addr, k - 1);
            check("win_ready_busy", win_ready, 0);
            check("out_valid_latency", out_valid, (k == 20));
        end
        window = fill_win(255);
        win_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, expect_vec(1));
            check("hold_win_ready", win_ready, 0);
        end
        win_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_win_ready", win_ready, 1);
        check("release_out_valid", out_valid, 0);

        run_window(2, 255);
        run_window(3, 1);

        // Flush in RUN: nothing may be presented for the aborted window.
        mode = 2;
        fire(fill_win(255));
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_win_ready", win_ready, 1);
        check("flush_w_addr", w_addr, 0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("flush_no_output", seen, 0);

        run_window(1, 1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
